// File: rtl/hilo_acc_unit.sv
// rtl/hilo_acc_unit.sv - Hi/Lo register pair with LOAD/MOVE and optional two-step ACC/SUB (HILO_ACC_EN)
module hilo_acc_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [2*WIDTH-1:0] DivAns,
    input  logic [WIDTH-1:0]   mt_data,
    input  logic               sel_hi,
    input  logic               sel_lo,
    output logic [WIDTH-1:0]   HiOut,
    output logic [WIDTH-1:0]   LoOut,
    output logic               busy,
    output logic               acc_ovf
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ACC  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MOVE = 2'b11;

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             accept;

    assign accept   = in_valid && in_ready;
    assign in_ready = !busy;
    assign HiOut    = hi_q;
    assign LoOut    = lo_q;

`ifdef HILO_ACC_EN

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LO_STEP = 2'b01,
        HI_STEP = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] opnd_q, opnd_d;
    logic               sub_q, sub_d;
    logic               cy_q, cy_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH:0]     lo_sum;
    logic [WIDTH:0]     hi_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (op == OP_ACC || op == OP_SUB)) state_d = LO_STEP;
            LO_STEP: state_d = HI_STEP;
            HI_STEP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        acc_ovf = ovf_q;
    end

    // Bit WIDTH of each partial result is the carry (ACC) or borrow (SUB) out of that half.
    always_comb begin
        if (sub_q) begin
            lo_sum = {1'b0, lo_q} - {1'b0, opnd_q[WIDTH-1:0]};
            hi_sum = {1'b0, hi_q} - {1'b0, opnd_q[2*WIDTH-1:WIDTH]} - {{WIDTH{1'b0}}, cy_q};
        end else begin
            lo_sum = {1'b0, lo_q} + {1'b0, opnd_q[WIDTH-1:0]};
            hi_sum = {1'b0, hi_q} + {1'b0, opnd_q[2*WIDTH-1:WIDTH]} + {{WIDTH{1'b0}}, cy_q};
        end
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        sub_d  = sub_q;
        cy_d   = cy_q;
        ovf_d  = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD: begin
                            {hi_d, lo_d} = DivAns;
                            ovf_d        = 1'b0;
                        end
                        OP_MOVE: begin
                            if (sel_hi) hi_d = mt_data;
                            if (sel_lo) lo_d = mt_data;
                        end
                        default: begin
                            opnd_d = DivAns;
                            sub_d  = (op == OP_SUB);
                        end
                    endcase
                end
            end
            LO_STEP: begin
                lo_d = lo_sum[WIDTH-1:0];
                cy_d = lo_sum[WIDTH];
            end
            HI_STEP: begin
                hi_d  = hi_sum[WIDTH-1:0];
                ovf_d = ovf_q | hi_sum[WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            sub_q  <= 1'b0;
            cy_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            sub_q  <= sub_d;
            cy_q   <= cy_d;
            ovf_q  <= ovf_d;
        end
    end

`else

    assign busy    = 1'b0;
    assign acc_ovf = 1'b0;

    // ACC and SUB are accepted and dropped so callers never stall.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (accept) begin
            case (op)
                OP_LOAD: {hi_d, lo_d} = DivAns;
                OP_MOVE: begin
                    if (sel_hi) hi_d = mt_data;
                    if (sel_lo) lo_d = mt_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`endif

endmodule

// File: tb/tb_hilo_acc_unit.sv
// tb/tb_hilo_acc_unit.sv - randomized self-checking bench for hilo_acc_unit against a 2W-bit arithmetic model
module tb_hilo_acc_unit;

    localparam logic [1:0] LOAD = 2'b00;
    localparam logic [1:0] ACC  = 2'b01;
    localparam logic [1:0] SUB  = 2'b10;
    localparam logic [1:0] MOVE = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [63:0] div_ans;
    logic [31:0] mt_data;
    logic        sel_hi;
    logic        sel_lo;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        acc_ovf;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_hi, m_lo;
    logic        m_ovf;

    always #5 clk = ~clk;

    hilo_acc_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .DivAns   (div_ans),
        .mt_data  (mt_data),
        .sel_hi   (sel_hi),
        .sel_lo   (sel_lo),
        .HiOut    (hi_out),
        .LoOut    (lo_out),
        .busy     (busy),
        .acc_ovf  (acc_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_hilo"}, {hi_out, lo_out}, {m_hi, m_lo});
        check({tag, "_ovf"}, {63'd0, acc_ovf}, {63'd0, m_ovf});
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 64'd0, 64'd1);
    endtask

    // Model: ACC/SUB is a single 65-bit add/subtract; bit 64 is the carry/borrow.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [63:0] d,
                         input logic [31:0] mt, input logic sh, input logic sl);
        logic [64:0] full;
        logic [31:0] old_hi, old_lo;
        wait_ready();
        op = o; div_ans = d; mt_data = mt; sel_hi = sh; sel_lo = sl; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        old_hi = m_hi;
        old_lo = m_lo;
        full = '0;
        case (o)
            LOAD: begin
                {m_hi, m_lo} = d;
                m_ovf = 1'b0;
            end
            MOVE: begin
                if (sh) m_hi = mt;
                if (sl) m_lo = mt;
            end
            default: begin
`ifdef HILO_ACC_EN
                if (o == ACC) full = {1'b0, old_hi, old_lo} + {1'b0, d};
                else          full = {1'b0, old_hi, old_lo} - {1'b0, d};
                m_ovf = m_ovf | full[64];
                {m_hi, m_lo} = full[63:0];
                check({tag, "_acc_busy"}, {63'd0, busy}, 64'd1);
                check({tag, "_acc_regs"}, {hi_out, lo_out}, {old_hi, old_lo});
                @(negedge clk);
                check({tag, "_lo_busy"}, {63'd0, busy}, 64'd1);
                check({tag, "_lo_regs"}, {hi_out, lo_out}, {old_hi, m_lo});
                @(negedge clk);
`endif
            end
        endcase
        check_state(tag);
    endtask

    initial begin
        logic [63:0] full;
        logic [63:0] d;
        logic [1:0]  o;
        reset = 1'b0; in_valid = 1'b0; op = LOAD; div_ans = '0; mt_data = '0;
        sel_hi = 1'b0; sel_lo = 1'b0;
        m_hi = '0; m_lo = '0; m_ovf = 1'b0;
        #12;
        check_state("reset");
        @(negedge clk);
        reset = 1'b1;

        do_op("load_a", LOAD, 64'h00000001_FFFFFFFF, 32'h0, 1'b0, 1'b0);
        do_op("acc_a", ACC, 64'h00000000_00000001, 32'h0, 1'b0, 1'b0);
`ifdef HILO_ACC_EN
        check("acc_a_const", {hi_out, lo_out}, 64'h00000002_00000000);
`endif
        do_op("load_b", LOAD, 64'hFFFFFFFF_FFFFFFFF, 32'h0, 1'b0, 1'b0);
        do_op("acc_b", ACC, 64'h1, 32'h0, 1'b0, 1'b0);
        do_op("move_hi", MOVE, 64'h0, 32'h5, 1'b1, 1'b0);
        do_op("load_0", LOAD, 64'h0, 32'h0, 1'b0, 1'b0);
        do_op("sub_1", SUB, 64'h1, 32'h0, 1'b0, 1'b0);
`ifdef HILO_ACC_EN
        check("sub_1_const", {63'd0, acc_ovf, hi_out, lo_out} >> 0, {hi_out == 32'hFFFFFFFF && lo_out == 32'hFFFFFFFF && acc_ovf} ? {63'd0, 1'b1, 64'hFFFFFFFF_FFFFFFFF} : 64'd0);
`endif
        do_op("move_both", MOVE, 64'h0, 32'hA5A5A5A5, 1'b1, 1'b1);
        do_op("move_none", MOVE, 64'h0, 32'h12345678, 1'b0, 1'b0);

`ifdef HILO_ACC_EN
        // Request held through a busy ACC is taken on the first ready edge.
        wait_ready();
        op = ACC; div_ans = 64'h00000003_80000000; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        full = {m_hi, m_lo} + 64'h00000003_80000000;
        op = LOAD; div_ans = 64'h1234;
        @(negedge clk);
        @(negedge clk);
        check("hold_ready", {63'd0, in_ready}, 64'd1);
        check("hold_regs", {hi_out, lo_out}, full);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        {m_hi, m_lo} = 64'h1234;
        m_ovf = 1'b0;
        check_state("hold_load");

        // Asynchronous reset in LO_STEP, sampled before any further clock edge.
        do_op("pre_rst", LOAD, 64'hDEADBEEF_CAFEF00D, 32'h0, 1'b0, 1'b0);
        op = ACC; div_ans = 64'h7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        m_hi = '0; m_lo = '0; m_ovf = 1'b0;
        check_state("mid_rst");
        @(negedge clk);
        reset = 1'b1;
`endif

        for (int i = 0; i < 250; i++) begin
            o = 2'($urandom_range(0, 3));
            d = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) d = 64'hFFFFFFFF_FFFFFFFF;
            do_op("rand", o, d, $urandom, 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
